// File: rtl/ysyx_22041752_axi_burst_arb_if.sv
// AXI4 master-port bundle (64-bit data, 32-bit address, 4-bit IDs) between the burst arbiter and the slave.
interface ysyx_22041752_axi_burst_arb_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;

    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready,
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready,
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready
    );
endinterface

// File: rtl/ysyx_22041752_axi_burst_arb.sv
// Round-robin AXI4 arbiter: icache burst refills vs. single-beat data reads/writes, one transaction in flight.
// Define ysyx_22041752_ARB_ERR_CHECK_EN to add sticky bus_err_o / err_addr_o response checking.
module ysyx_22041752_axi_burst_arb #(
    parameter int unsigned IC_BURST_LEN = 4,
    parameter int unsigned IC_ID        = 0,
    parameter int unsigned D_ID         = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ic_req_i,
    input  logic [31:0] ic_addr_i,
    input  logic        ic_abort_i,
    output logic        ic_ready_o,
    output logic        ic_rvalid_o,
    output logic [63:0] ic_rdata_o,
    output logic        ic_rlast_o,
    input  logic        d_req_i,
    input  logic [7:0]  d_wen_i,
    input  logic [31:0] d_addr_i,
    input  logic [63:0] d_wdata_i,
    output logic        d_ready_o,
    output logic        d_rvalid_o,
    output logic [63:0] d_rdata_o,
    output logic        d_bvalid_o,
    ysyx_22041752_axi_burst_arb_if.master axi
`ifdef ysyx_22041752_ARB_ERR_CHECK_EN
    ,
    output logic        bus_err_o,
    output logic [31:0] err_addr_o
`endif
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned BEAT_W = 4;
    localparam logic [2:0]  AXI_SIZE_8B = 3'b011;
    localparam logic [1:0]  AXI_INCR    = 2'b01;
    localparam logic        GNT_IC      = 1'b0;
    localparam logic        GNT_D       = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_IC_AR, S_IC_R, S_D_AR, S_D_R, S_D_AW_W, S_D_B
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [STRB_W-1:0]   wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                abort_q, abort_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                grant_ic_c, grant_d_c;

    // With both requesting, the side that did not win last time gets the bus.
    assign grant_ic_c = ~reset & ic_req_i & (~d_req_i | (last_grant_q == GNT_D));
    assign grant_d_c  = ~reset & d_req_i & (~ic_req_i | (last_grant_q == GNT_IC));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_IC;
            addr_q       <= '0;
            wen_q        <= '0;
            wdata_q      <= '0;
            abort_q      <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            abort_q      <= abort_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        abort_d      = abort_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;

        ic_ready_o  = 1'b0;
        ic_rvalid_o = 1'b0;
        ic_rdata_o  = '0;
        ic_rlast_o  = 1'b0;
        d_ready_o   = 1'b0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        d_bvalid_o  = 1'b0;

        axi.arvalid = 1'b0;
        axi.arid    = '0;
        axi.araddr  = addr_q;
        axi.arlen   = '0;
        axi.arsize  = AXI_SIZE_8B;
        axi.arburst = AXI_INCR;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.awid    = ID_W'(D_ID);
        axi.awaddr  = addr_q;
        axi.awlen   = '0;
        axi.awsize  = AXI_SIZE_8B;
        axi.awburst = AXI_INCR;
        axi.wvalid  = 1'b0;
        axi.wdata   = wdata_q;
        axi.wstrb   = wen_q;
        axi.wlast   = 1'b1;
        axi.bready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                abort_d   = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (grant_ic_c) begin
                    ic_ready_o   = 1'b1;
                    addr_d       = ic_addr_i;
                    last_grant_d = GNT_IC;
                    state_d      = S_IC_AR;
                end else if (grant_d_c) begin
                    d_ready_o    = 1'b1;
                    addr_d       = d_addr_i;
                    wen_d        = d_wen_i;
                    wdata_d      = d_wdata_i;
                    last_grant_d = GNT_D;
                    state_d      = (d_wen_i == '0) ? S_D_AR : S_D_AW_W;
                end
            end
            S_IC_AR: begin
                axi.arvalid = 1'b1;
                axi.arid    = ID_W'(IC_ID);
                axi.arlen   = LEN_W'(IC_BURST_LEN - 1);
                if (ic_abort_i) abort_d = 1'b1;
                if (axi.arready) state_d = S_IC_R;
            end
            S_IC_R: begin
                axi.rready  = 1'b1;
                ic_rvalid_o = axi.rvalid & ~abort_q;
                ic_rdata_o  = axi.rdata;
                ic_rlast_o  = axi.rlast;
                // The last beat ends the refill, so an abort arriving with it changes nothing.
                if (axi.rvalid && axi.rlast) state_d = S_IDLE;
                else if (ic_abort_i)         abort_d = 1'b1;
            end
            S_D_AR: begin
                axi.arvalid = 1'b1;
                axi.arid    = ID_W'(D_ID);
                if (axi.arready) state_d = S_D_R;
            end
            S_D_R: begin
                axi.rready = 1'b1;
                d_rvalid_o = axi.rvalid;
                d_rdata_o  = axi.rdata;
                if (axi.rvalid) state_d = S_IDLE;
            end
            S_D_AW_W: begin
                axi.awvalid = ~aw_done_q;
                axi.wvalid  = ~w_done_q;
                aw_done_d   = aw_done_q | axi.awready;
                w_done_d    = w_done_q | axi.wready;
                if (aw_done_d && w_done_d) state_d = S_D_B;
            end
            S_D_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    d_bvalid_o = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ysyx_22041752_ARB_ERR_CHECK_EN
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              bus_err_q, bus_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              err_c;

    // Flags bad responses, wrong IDs and refills whose rlast is not on the expected beat.
    always_comb begin
        err_c      = 1'b0;
        beat_d     = '0;
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;
        case (state_q)
            S_IC_R: begin
                beat_d = axi.rvalid ? beat_q + BEAT_W'(1) : beat_q;
                if (axi.rvalid)
                    err_c = (axi.rresp != 2'b00) || (axi.rid != ID_W'(IC_ID)) ||
                            (axi.rlast != (beat_q == BEAT_W'(IC_BURST_LEN - 1)));
            end
            S_D_R: if (axi.rvalid) err_c = (axi.rresp != 2'b00) || (axi.rid != ID_W'(D_ID));
            S_D_B: if (axi.bvalid) err_c = (axi.bresp != 2'b00) || (axi.bid != ID_W'(D_ID));
            default: err_c = 1'b0;
        endcase
        if (err_c && !bus_err_q) begin
            bus_err_d  = 1'b1;
            err_addr_d = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q     <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            beat_q     <= beat_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus_err_o  = bus_err_q;
    assign err_addr_o = err_addr_q;
`else
    logic unused_resp_c;
    assign unused_resp_c = ^{axi.rresp, axi.rid, axi.bresp, axi.bid, BEAT_W'(0)};
`endif
endmodule
